// File: rtl/taus_rng_arbiter_pkg.sv
// Shared constants for the Tausworthe RNG arbiter: per-component step
// constants, default seeds and the controller state encoding.
package taus_rng_arbiter_pkg;

    localparam int          C1_L1 = 13;
    localparam int          C1_R  = 19;
    localparam logic [31:0] C1_C  = 32'hFFFF_FFFE;
    localparam int          C1_L2 = 12;

    localparam int          C2_L1 = 2;
    localparam int          C2_R  = 25;
    localparam logic [31:0] C2_C  = 32'hFFFF_FFF8;
    localparam int          C2_L2 = 4;

    localparam int          C3_L1 = 3;
    localparam int          C3_R  = 11;
    localparam logic [31:0] C3_C  = 32'hFFFF_FFF0;
    localparam int          C3_L2 = 17;

    localparam logic [31:0] DEF_SEED1 = 32'h0000_1234;
    localparam logic [31:0] DEF_SEED2 = 32'h0000_5678;
    localparam logic [31:0] DEF_SEED3 = 32'h0000_9ABC;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/taus_rng_arbiter_step.sv
// One combinational Tausworthe component step; shift/mask constants come
// in as parameters so the same block serves all three components.
module taus_step #(
    parameter int          L1 = 13,
    parameter int          R  = 19,
    parameter logic [31:0] C  = 32'hFFFF_FFFE,
    parameter int          L2 = 12
) (
    input  logic [31:0] s,
    output logic [31:0] next
);

    assign next = (((s << L1) ^ s) >> R) ^ ((s & C) << L2);

endmodule

// File: rtl/taus_rng_arbiter.sv
// Round-robin arbiter handing out words from a three-component Tausworthe
// generator; the generator only advances on warm-up cycles and on grants.
module taus_rng_arbiter
    import taus_rng_arbiter_pkg::*;
#(
    parameter int          N_REQ  = 4,
    parameter int          WARMUP = 8,
    parameter logic [31:0] SEED1  = DEF_SEED1,
    parameter logic [31:0] SEED2  = DEF_SEED2,
    parameter logic [31:0] SEED3  = DEF_SEED3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             seed_load,
    input  logic [95:0]      seed_data,
    output logic             ready
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        cnt_inc;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [31:0]       s1, s2, s3;
    logic [31:0]       n1, n2, n3;
    logic [31:0]       seed1, seed2, seed3;
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_oh;
    logic [PW:0]       sum;

    taus_step #(.L1(C1_L1), .R(C1_R), .C(C1_C), .L2(C1_L2)) u_step1 (.s(s1), .next(n1));
    taus_step #(.L1(C2_L1), .R(C2_R), .C(C2_C), .L2(C2_L2)) u_step2 (.s(s2), .next(n2));
    taus_step #(.L1(C3_L1), .R(C3_R), .C(C3_C), .L2(C3_L2)) u_step3 (.s(s3), .next(n3));

    // A seed whose masked bits are all zero would lock that component at zero.
    assign seed1 = ((seed_data[31:0]  & C1_C) == 32'd0) ? SEED1 : seed_data[31:0];
    assign seed2 = ((seed_data[63:32] & C2_C) == 32'd0) ? SEED2 : seed_data[63:32];
    assign seed3 = ((seed_data[95:64] & C3_C) == 32'd0) ? SEED3 : seed_data[95:64];

    assign cnt_inc = cnt + 8'd1;

    // Search starts at ptr, the index just after the previous grant.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        sum        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            if (!pick_valid && req[sum[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = sum[PW-1:0];
            end
        end
        if (pick_valid) begin
            pick_oh[pick_idx] = 1'b1;
        end
    end

    assign ptr_next = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= SEED1;
            s2        <= SEED2;
            s3        <= SEED3;
            state     <= WARM;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ready     <= 1'b0;
        end else if (seed_load) begin
            s1        <= seed1;
            s2        <= seed2;
            s3        <= seed3;
            state     <= WARM;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state)
                WARM: begin
                    s1        <= n1;
                    s2        <= n2;
                    s3        <= n3;
                    cnt       <= cnt_inc;
                    gnt       <= '0;
                    out_valid <= 1'b0;
                    if (cnt_inc == 8'(WARMUP)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (pick_valid) begin
                        s1        <= n1;
                        s2        <= n2;
                        s3        <= n3;
                        gnt       <= pick_oh;
                        out_valid <= 1'b1;
                        out_data  <= n1 ^ n2 ^ n3;
                        ptr       <= ptr_next;
                    end else begin
                        gnt       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= WARM;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_taus_rng_arbiter.sv
// Directed bench for taus_rng_arbiter: table of grant vectors plus
// hand-written reset, reseed and asynchronous-reset sequences.
module tb_taus_rng_arbiter;

    localparam int          N_REQ  = 4;
    localparam int          WARMUP = 8;
    localparam logic [31:0] S1 = 32'h0000_1234;
    localparam logic [31:0] S2 = 32'h0000_5678;
    localparam logic [31:0] S3 = 32'h0000_9ABC;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [31:0] out_data;
    logic        seed_load;
    logic [95:0] seed_data;
    logic        ready;

    always #5 clk = ~clk;

    taus_rng_arbiter #(.N_REQ(N_REQ), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data),
        .seed_load(seed_load), .seed_data(seed_data), .ready(ready)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       valid;
    } vec_t;

    vec_t        vecs[17];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] m1, m2, m3;
    logic [31:0] w;
    logic [31:0] first_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] comp(input logic [31:0] s, input int l1, input int r,
                                         input logic [31:0] c, input int l2);
        return (((s << l1) ^ s) >> r) ^ ((s & c) << l2);
    endfunction

    task automatic model_step(output logic [31:0] word);
        m1 = comp(m1, 13, 19, 32'hFFFF_FFFE, 12);
        m2 = comp(m2, 2, 25, 32'hFFFF_FFF8, 4);
        m3 = comp(m3, 3, 11, 32'hFFFF_FFF0, 17);
        word = m1 ^ m2 ^ m3;
    endtask

    task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] dummy;
        m1 = a; m2 = b; m3 = c;
        for (int i = 0; i < WARMUP; i++) model_step(dummy);
    endtask

    // Waits for the first grant after a warm-up, bounded, and checks its latency.
    task automatic wait_first_valid(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 50) begin
            tick();
            cyc++;
            if (out_valid) break;
        end
        check(name, 32'(cyc), 32'(WARMUP + 1));
    endtask

    task automatic reseed_run(input logic [95:0] sd, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input bit async_rst);
        logic [31:0] word;
        req = 4'b1111;
        seed_data = sd;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("reseed_no_valid", 32'(out_valid), 32'd0);
        model_seed(e1, e2, e3);
        wait_first_valid("reseed_latency");
        check("reseed_gnt0", 32'(gnt), 32'h1);
        model_step(word);
        check("reseed_data0", out_data, word);
        if (async_rst) begin
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_gnt", 32'(gnt), 32'd0);
            check("async_rst_valid", 32'(out_valid), 32'd0);
            check("async_rst_data", out_data, 32'd0);
            check("async_rst_ready", 32'(ready), 32'd0);
            tick();
            rst = 1'b0;
        end else begin
            tick();
            check("reseed_gnt1", 32'(gnt), 32'h2);
            model_step(word);
            check("reseed_data1", out_data, word);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b1111, 4'b0010, 1'b1};
        vecs[1]  = '{4'b1111, 4'b0100, 1'b1};
        vecs[2]  = '{4'b1111, 4'b1000, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0001, 1'b1};
        vecs[4]  = '{4'b0010, 4'b0010, 1'b1};
        vecs[5]  = '{4'b1010, 4'b1000, 1'b1};
        vecs[6]  = '{4'b1010, 4'b0010, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{4'b0001, 4'b0001, 1'b1};
        vecs[13] = '{4'b0101, 4'b0100, 1'b1};
        vecs[14] = '{4'b0101, 4'b0001, 1'b1};
        vecs[15] = '{4'b1100, 4'b0100, 1'b1};
        vecs[16] = '{4'b1100, 4'b1000, 1'b1};

        rst = 1'b1;
        req = 4'b1111;
        seed_load = 1'b0;
        seed_data = '0;
        repeat (2) tick();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_ready", 32'(ready), 32'd0);

        rst = 1'b0;
        model_seed(S1, S2, S3);
        wait_first_valid("first_valid_latency");
        check("first_gnt", 32'(gnt), 32'h1);
        model_step(w);
        check("first_data", out_data, w);
        first_word = w;

        for (int i = 0; i < 17; i++) begin
            req = vecs[i].req;
            tick();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
            if (vecs[i].valid) begin
                model_step(w);
                check($sformatf("vec%0d_data", i), out_data, w);
            end
        end

        // Reseed with all-zero seeds in the same cycle as a request.
        req = 4'b0100;
        seed_data = '0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed_cycle_gnt", 32'(gnt), 32'd0);
        check("seed_cycle_valid", 32'(out_valid), 32'd0);
        check("seed_cycle_ready", 32'(ready), 32'd0);
        model_seed(S1, S2, S3);
        for (int k = 1; k < WARMUP; k++) begin
            tick();
            check($sformatf("warm%0d_ready", k), 32'(ready), 32'd0);
            check($sformatf("warm%0d_gnt", k), 32'(gnt), 32'd0);
        end
        tick();
        check("warm_end_ready", 32'(ready), 32'd1);
        check("warm_end_gnt", 32'(gnt), 32'd0);
        tick();
        check("after_seed_gnt", 32'(gnt), 32'h4);
        model_step(w);
        check("after_seed_data", out_data, w);
        check("after_seed_matches_reset", out_data, first_word);

        // Partial substitution: comp2 and comp3 masked to zero, comp1 kept.
        reseed_run({32'h0000_000F, 32'h0000_0007, 32'hDEAD_BEEF}, 32'hDEAD_BEEF, S2, S3, 1'b0);
        // Only comp1 substituted; then async reset during a grant.
        reseed_run({32'hCAFE_0010, 32'h0000_0008, 32'h0000_0001}, S1, 32'h0000_0008, 32'hCAFE_0010, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/taus_rng_arbiter.md
TAUS_RNG_ARBITER -- requirements
Module: taus_rng_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter WARMUP, default 8: generator steps discarded after reset or reseed, range 1..255.
REQ-003 SHALL have parameters SEED1, SEED2, SEED3, defaults 32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC: reset seeds of the three components.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port req, input, N_REQ bits: level request, one bit per requester.
REQ-007 SHALL have port gnt, output, N_REQ bits: registered one-hot grant, held for one cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data carries a fresh word this cycle.
REQ-009 SHALL have port out_data, output, 32 bits: random word delivered to the granted requester.
REQ-010 SHALL have port seed_load, input, 1 bit: single-cycle reseed strobe.
REQ-011 SHALL have port seed_data, input, 96 bits: seeds; [31:0] comp1, [63:32] comp2, [95:64] comp3.
REQ-012 SHALL have port ready, output, 1 bit: high in RUN state only.

Function
REQ-013 SHALL hold three 32-bit component states s1, s2, s3.
REQ-014 SHALL compute each component step as next = (((s << L1) ^ s) >> R) ^ ((s & C) << L2), in 32-bit arithmetic with overflow bits discarded.
REQ-015 SHALL use step constants (L1, R, C, L2) = (13, 19, FFFFFFFE, 12) for comp1, (2, 25, FFFFFFF8, 4) for comp2, and (3, 11, FFFFFFF0, 17) for comp3.
REQ-016 SHALL form the combined word as next1 ^ next2 ^ next3.
REQ-017 SHALL implement a state machine with states WARM and RUN; reset enters WARM with warm-up counter 0.
REQ-018 In WARM, SHALL step all components every cycle and increment the counter.
REQ-019 In WARM, SHALL move to RUN on the cycle the counter reaches WARMUP; gnt = 0 and out_valid = 0 throughout WARM.
REQ-020 In RUN with req != 0, SHALL grant exactly one requester chosen round-robin.
REQ-021 On a RUN grant, SHALL step the components and register gnt, out_valid = 1 and out_data = combined word; the outputs are visible the cycle after req is sampled (1-cycle latency).
REQ-022 In RUN with req == 0, SHALL hold component state, with gnt = 0 and out_valid = 0.
REQ-023 Round-robin rule: the search starts at the index after the last grant and wraps from N_REQ-1 to 0; the pointer is 0 after reset and after reseed.
REQ-024 A requester holding req high SHALL be granted again only after every other active requester has been served.
REQ-025 seed_load = 1 in any state SHALL load s1/s2/s3 from seed_data, clear the counter and enter WARM.
REQ-026 A seed_load cycle SHALL take priority over req: no grant and no step that cycle.
REQ-027 Any seed component with (seed & C) == 0 SHALL be replaced by the corresponding SEEDn parameter.
REQ-028 Requests are not queued: a req bit dropped before it is granted is lost.

Reset
REQ-029 On rst, SHALL asynchronously set s1/s2/s3 = SEED1/SEED2/SEED3, state = WARM, counter = 0 and pointer = 0.
REQ-030 On rst, SHALL asynchronously set gnt = 0, out_valid = 0, out_data = 0 and ready = 0.
REQ-031 Reset asserted mid-grant SHALL clear gnt and out_valid immediately, without waiting for a clock edge.

Structure
REQ-032 A shared package SHALL hold the per-component constant sets (L1, R, C, L2), the default seeds, and the state encoding (WARM, RUN).
REQ-033 SHALL contain one sub-module, taus_step: a combinational single-component step parameterised by L1, R, C and L2, instantiated three times.
REQ-034 The arbiter, state machine and seed substitution SHALL live in the top module.

Verification
REQ-035 Reset, req = 4'b1111 held -> first out_valid exactly WARMUP+1 cycles after rst deasserts; gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-036 Free-running run, N_REQ = 4 -> every out_data equals a C model of REQ-014..016 started from SEED1..3 and stepped WARMUP times.
REQ-037 seed_load with seed_data = 0 -> all three components substituted; output sequence identical to the one after reset.
REQ-038 In RUN, req = 4'b0100 with seed_load = 1 in the same cycle -> no grant; ready = 0 for WARMUP cycles; first subsequent grant = 0100.
REQ-039 req = 4'b1010 after last grant 0010 -> next gnt 1000, then 0010; with req = 0 for 5 cycles -> state held, next word continues the sequence.
REQ-040 rst asserted asynchronously while gnt = 0001 -> gnt, out_valid and out_data = 0 before the next clock edge.
